// File: rtl/audio_pkg.sv
// audio_pkg: shared constants and helpers for the I2S transmitter.
//   BCLK_DIV / FRAME_BITS / SLOT_BITS : fixed I2S frame geometry
//   LR_RISE_CNT / LR_FALL_CNT         : bit-counter values on entry to which
//                                       LRCLK switches to right / left
//   LOAD_CNT                          : bit-counter value of the frame-load slot
//   lrclk_next()                      : next word-select value for a new count
package audio_pkg;

  localparam int BCLK_DIV   = 4;
  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int CNT_W = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(BCLK_DIV - 1);
  localparam logic [CNT_W-1:0] LR_RISE_CNT = 6'd31;
  localparam logic [CNT_W-1:0] LR_FALL_CNT = 6'd63;
  localparam logic [CNT_W-1:0] LOAD_CNT    = 6'd63;

  // Word-select encoding on i2s_lrclk.
  typedef enum logic {
    WS_LEFT  = 1'b0,
    WS_RIGHT = 1'b1
  } ws_e;

  // LRCLK leads the data by one BCLK: it flips on entry to the last bit
  // of the preceding slot.
  function automatic logic lrclk_next(input logic cur, input logic [CNT_W-1:0] cnt_new);
    if (cnt_new == LR_RISE_CNT) begin
      return WS_RIGHT;
    end else if (cnt_new == LR_FALL_CNT) begin
      return WS_LEFT;
    end else begin
      return cur;
    end
  endfunction

endpackage

// File: rtl/audio_sync_fifo.sv
// audio_sync_fifo: single-clock FIFO with show-ahead read port.
//   clk      : clock
//   rst      : synchronous active-high reset (empties the FIFO)
//   wr_en    : write request, ignored while full
//   wr_data  : write data
//   rd_en    : read request (advances the read pointer), ignored while empty
//   rd_data  : entry at the head of the FIFO (valid while !empty)
//   full     : DEPTH entries held
//   empty    : no entries held
//   level    : number of entries held
// Pointers carry one extra MSB so full and empty are told apart without a
// separate counter.
module audio_sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_fire;
  logic             rd_fire;

  assign wr_fire = wr_en & ~full;
  assign rd_fire = rd_en & ~empty;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S master transmitter, 64 BCLK per stereo frame.
//   mclk         : 12.288 MHz audio master clock (sole clock)
//   reset        : synchronous active-high reset
//   pll_locked   : low acts exactly like reset
//   enable       : run BCLK/LRCLK and the frame engine
//   s_valid/s_ready/s_left/s_right : stereo frame input
//   i2s_bclk     : mclk/4 bit clock
//   i2s_lrclk    : word select (0 = left, 1 = right)
//   i2s_sd       : serial data, MSB first, changes on BCLK falling edges
//   fifo_level   : frames currently buffered
//   underrun     : sticky flag, set when a frame load finds the FIFO empty
//   underrun_clr : clears underrun (a coincident new underrun wins)
//   underrun_cnt : saturating underrun counter
// Optional feature macro: AUDIO_I2S_TX_UNDERRUN_CNT_EN enables underrun_cnt;
// without it underrun_cnt is tied to 0.
//
// Handshake: a frame transfers on every mclk edge where s_valid & s_ready;
// s_valid may be raised at any time and the sender keeps s_left/s_right
// stable until the transfer; s_ready is registered and only reflects FIFO
// space, never s_valid.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int DW         = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          mclk,
  input  logic                          reset,
  input  logic                          pll_locked,
  input  logic                          enable,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DW-1:0]                 s_left,
  input  logic [DW-1:0]                 s_right,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  input  logic                          underrun_clr,
  output logic [15:0]                   underrun_cnt
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                  srst;
  logic                  push;
  logic                  pop;
  logic                  bclk_fall;
  logic                  load;
  logic                  underrun_evt;

  logic [DIV_W-1:0]      div;
  logic [DIV_W-1:0]      div_inc;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_inc;

  logic [2*DW-1:0]       fifo_rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [LW-1:0]         level_next;

  logic [DW-1:0]         rd_left;
  logic [DW-1:0]         rd_right;
  logic [SLOT_BITS-1:0]  left_slot;
  logic [SLOT_BITS-1:0]  right_slot;
  logic [FRAME_BITS-1:0] frame_new;
  logic [FRAME_BITS-1:0] shreg;

  assign srst = reset | ~pll_locked;

  // ---------------------------------------------------------------------
  // Frame buffer
  // ---------------------------------------------------------------------
  assign push = s_valid & s_ready & ~fifo_full;
  assign pop  = load & ~fifo_empty;

  audio_sync_fifo #(
    .WIDTH (2 * DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (mclk),
    .rst     (srst),
    .wr_en   (push),
    .wr_data ({s_left, s_right}),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // s_ready is registered, so it must look at the level after this cycle's
  // push/pop or a frame could be accepted into a full FIFO.
  assign level_next = fifo_level + LW'(push) - LW'(pop);

  // ---------------------------------------------------------------------
  // Clock division and frame timing
  // ---------------------------------------------------------------------
  assign div_inc      = div + 1'b1;
  assign cnt_inc      = cnt + 1'b1;
  assign bclk_fall    = enable & (div == DIV_LAST);
  assign load         = bclk_fall & (cnt == LOAD_CNT);
  assign underrun_evt = load & fifo_empty;

  // Samples are MSB-justified in their 32-bit slot; unused LSBs are 0.
  assign {rd_left, rd_right} = fifo_rd_data;
  assign left_slot  = SLOT_BITS'(rd_left)  << (SLOT_BITS - DW);
  assign right_slot = SLOT_BITS'(rd_right) << (SLOT_BITS - DW);
  // No bypass: a load from an empty FIFO plays silence even if a frame is
  // being pushed in the same cycle.
  assign frame_new  = fifo_empty ? '0 : {left_slot, right_slot};

  always_ff @(posedge mclk) begin
    if (srst) begin
      div       <= '0;
      cnt       <= '0;
      i2s_bclk  <= 1'b0;
      i2s_lrclk <= WS_LEFT;
      i2s_sd    <= 1'b0;
      shreg     <= '0;
      s_ready   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      s_ready <= (level_next != LW'(FIFO_DEPTH));

      if (underrun_evt) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end

      if (!enable) begin
        // Parked: line idles low and the next start is a fresh frame at cnt 0.
        div       <= '0;
        cnt       <= '0;
        i2s_bclk  <= 1'b0;
        i2s_lrclk <= WS_LEFT;
        i2s_sd    <= 1'b0;
        shreg     <= '0;
      end else begin
        div      <= div_inc;
        // Registered copy of the divider MSB: BCLK falls on the same edge
        // that updates sd and lrclk.
        i2s_bclk <= div_inc[DIV_W-1];
        if (bclk_fall) begin
          cnt       <= cnt_inc;
          i2s_lrclk <= lrclk_next(i2s_lrclk, cnt_inc);
          if (load) begin
            i2s_sd <= frame_new[FRAME_BITS-1];
            shreg  <= {frame_new[FRAME_BITS-2:0], 1'b0};
          end else begin
            i2s_sd <= shreg[FRAME_BITS-1];
            shreg  <= {shreg[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Underrun event counter
  // ---------------------------------------------------------------------
`ifdef AUDIO_I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] ur_cnt;

  always_ff @(posedge mclk) begin
    if (srst) begin
      ur_cnt <= '0;
    end else if (underrun_evt) begin
      // A clear coinciding with an event restarts the count at that event.
      if (underrun_clr) begin
        ur_cnt <= 16'd1;
      end else if (ur_cnt != 16'hFFFF) begin
        ur_cnt <= ur_cnt + 16'd1;
      end
    end else if (underrun_clr) begin
      ur_cnt <= '0;
    end
  end

  assign underrun_cnt = ur_cnt;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: directed bench for audio_i2s_tx (DW=24 instance plus a
// DW=16 instance). Expected bit streams come from a small slot model.
module tb_audio_i2s_tx;

`ifdef AUDIO_I2S_TX_UNDERRUN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic mclk;
  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // DW=24 instance
  logic        reset, pll_locked, enable, s_valid, s_ready, underrun_clr;
  logic [23:0] s_left, s_right;
  logic        i2s_bclk, i2s_lrclk, i2s_sd, underrun;
  logic [2:0]  fifo_level;
  logic [15:0] underrun_cnt;

  // DW=16 instance
  logic        reset16, enable16, s_valid16, s_ready16;
  logic [15:0] s_left16, s_right16;
  logic        bclk16, lrclk16, sd16, underrun16;
  logic [2:0]  level16;
  logic [15:0] ucnt16;

  audio_i2s_tx #(.DW(24), .FIFO_DEPTH(4)) u_dut (
    .mclk(mclk), .reset(reset), .pll_locked(pll_locked), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sd(i2s_sd),
    .fifo_level(fifo_level), .underrun(underrun), .underrun_clr(underrun_clr),
    .underrun_cnt(underrun_cnt)
  );

  audio_i2s_tx #(.DW(16), .FIFO_DEPTH(4)) u_dut16 (
    .mclk(mclk), .reset(reset16), .pll_locked(1'b1), .enable(enable16),
    .s_valid(s_valid16), .s_ready(s_ready16), .s_left(s_left16), .s_right(s_right16),
    .i2s_bclk(bclk16), .i2s_lrclk(lrclk16), .i2s_sd(sd16),
    .fifo_level(level16), .underrun(underrun16), .underrun_clr(1'b0),
    .underrun_cnt(ucnt16)
  );

  int checks = 0;
  int errors = 0;
  int k;   // index of the last posedge since the current run started

  // ---------------- model ----------------
  function automatic logic exp_sd(input int dw, input logic [31:0] l,
                                  input logic [31:0] r, input int c);
    if (c < dw) return l[dw-1-c];
    if (c >= 32 && c < 32 + dw) return r[dw-1-(c-32)];
    return 1'b0;
  endfunction

  function automatic logic exp_lr(input int c);
    return (c >= 31 && c <= 62);
  endfunction

  // Negedge after posedge E_k; bit c of frame f is stable at k = 4*(64f+c)+1.
  function automatic int bit_step(input int f, input int c);
    return 4 * (64 * f + c) + 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge mclk);
    k = k + 1;
  endtask

  task automatic goto(input int t);
    if (k > t) begin
      errors++;
      $display("FAIL goto: already at step %0d, required %0d", k, t);
    end
    while (k < t) step();
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    s_valid = 1'b1; s_left = l; s_right = r;
    step();
    s_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; pll_locked = 1'b1; enable = 1'b1;
    repeat (3) step();
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b exp 0", s_ready); end
    checks++; if (i2s_bclk !== 1'b0) begin errors++; $display("FAIL reset_bclk: got %b exp 0", i2s_bclk); end
    checks++; if (i2s_lrclk !== 1'b0) begin errors++; $display("FAIL reset_lrclk: got %b exp 0", i2s_lrclk); end
    checks++; if (i2s_sd !== 1'b0) begin errors++; $display("FAIL reset_sd: got %b exp 0", i2s_sd); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d exp 0", fifo_level); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b exp 0", underrun); end
    checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL reset_ucnt: got %0d exp 0", underrun_cnt); end
    reset = 1'b0;
    k = -1;
    step();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL release_s_ready: got %b exp 1", s_ready); end
    for (int i = 0; i < 8; i++) begin
      goto(i);
      checks++;
      if (i2s_bclk !== (((i + 1) % 4) >= 2)) begin
        errors++; $display("FAIL bclk_period step %0d: got %b exp %b", i, i2s_bclk, (((i + 1) % 4) >= 2));
      end
    end
  endtask

  task automatic test_basic_frame();
    push(24'hA5A5A5, 24'h5A5A5A);
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL basic_level: got %0d exp 1", fifo_level); end
    for (int c = 3; c < 64; c++) begin
      goto(bit_step(0, c));
      checks++; if (i2s_sd !== 1'b0) begin errors++; $display("FAIL frame0_sd c=%0d: got %b exp 0", c, i2s_sd); end
      checks++; if (i2s_lrclk !== exp_lr(c)) begin errors++; $display("FAIL frame0_lr c=%0d: got %b exp %b", c, i2s_lrclk, exp_lr(c)); end
    end
    goto(255);
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL basic_pop_level: got %0d exp 0", fifo_level); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL basic_underrun: got %b exp 0", underrun); end
    for (int c = 0; c < 64; c++) begin
      goto(bit_step(1, c));
      checks++;
      if (i2s_sd !== exp_sd(24, 32'hA5A5A5, 32'h5A5A5A, c)) begin
        errors++; $display("FAIL basic_sd c=%0d: got %b exp %b", c, i2s_sd, exp_sd(24, 32'hA5A5A5, 32'h5A5A5A, c));
      end
      checks++; if (i2s_lrclk !== exp_lr(c)) begin errors++; $display("FAIL basic_lr c=%0d: got %b exp %b", c, i2s_lrclk, exp_lr(c)); end
    end
  endtask

  task automatic test_underrun();
    goto(512);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur1_flag: got %b exp 1", underrun); end
    checks++; if (underrun_cnt !== (CNT_EN ? 16'd1 : 16'd0)) begin errors++; $display("FAIL ur1_cnt: got %0d exp %0d", underrun_cnt, CNT_EN ? 1 : 0); end
    for (int f = 2; f < 4; f++) begin
      for (int c = 0; c < 64; c++) begin
        goto(bit_step(f, c));
        checks++; if (i2s_sd !== 1'b0) begin errors++; $display("FAIL ur_sd f=%0d c=%0d: got %b exp 0", f, c, i2s_sd); end
      end
      if (f == 2) begin
        goto(768);
        checks++; if (underrun_cnt !== (CNT_EN ? 16'd2 : 16'd0)) begin errors++; $display("FAIL ur2_cnt: got %0d exp %0d", underrun_cnt, CNT_EN ? 2 : 0); end
      end
    end
    goto(1022);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_clr_coinc_flag: got %b exp 1", underrun); end
    checks++; if (underrun_cnt !== (CNT_EN ? 16'd1 : 16'd0)) begin errors++; $display("FAIL ur_clr_coinc_cnt: got %0d exp %0d", underrun_cnt, CNT_EN ? 1 : 0); end
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clr_flag: got %b exp 0", underrun); end
    checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL ur_clr_cnt: got %0d exp 0", underrun_cnt); end
  endtask

  task automatic test_no_bypass();
    goto(1278);
    push(24'hC00003, 24'h3FFFFC);   // lands on the frame-4 load edge
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL nobyp_flag: got %b exp 1", underrun); end
    checks++; if (underrun_cnt !== (CNT_EN ? 16'd1 : 16'd0)) begin errors++; $display("FAIL nobyp_cnt: got %0d exp %0d", underrun_cnt, CNT_EN ? 1 : 0); end
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL nobyp_level: got %0d exp 1", fifo_level); end
    for (int c = 0; c < 64; c++) begin
      goto(bit_step(5, c));
      checks++; if (i2s_sd !== 1'b0) begin errors++; $display("FAIL nobyp_silent c=%0d: got %b exp 0", c, i2s_sd); end
    end
    goto(1534);
    push(24'h000001, 24'h800000);   // push and pop on the same edge
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL pushpop_level: got %0d exp 1", fifo_level); end
    checks++; if (underrun_cnt !== (CNT_EN ? 16'd1 : 16'd0)) begin errors++; $display("FAIL pushpop_cnt: got %0d exp %0d", underrun_cnt, CNT_EN ? 1 : 0); end
    for (int c = 0; c < 64; c++) begin
      goto(bit_step(6, c));
      checks++;
      if (i2s_sd !== exp_sd(24, 32'hC00003, 32'h3FFFFC, c)) begin
        errors++; $display("FAIL nobyp_play c=%0d: got %b exp %b", c, i2s_sd, exp_sd(24, 32'hC00003, 32'h3FFFFC, c));
      end
    end
    for (int c = 0; c < 64; c++) begin
      goto(bit_step(7, c));
      checks++;
      if (i2s_sd !== exp_sd(24, 32'h000001, 32'h800000, c)) begin
        errors++; $display("FAIL pushpop_play c=%0d: got %b exp %b", c, i2s_sd, exp_sd(24, 32'h000001, 32'h800000, c));
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [23:0] fl [4];
    logic [23:0] fr [4];
    fl[0] = 24'h123456; fr[0] = 24'hABCDEF;
    fl[1] = 24'hFEDCBA; fr[1] = 24'h0F0F0F;
    fl[2] = 24'h111111; fr[2] = 24'h222222;
    fl[3] = 24'h800001; fr[3] = 24'h7FFFFE;
    enable = 1'b0;
    step();
    checks++; if (i2s_bclk !== 1'b0) begin errors++; $display("FAIL dis_bclk: got %b exp 0", i2s_bclk); end
    checks++; if (i2s_lrclk !== 1'b0) begin errors++; $display("FAIL dis_lrclk: got %b exp 0", i2s_lrclk); end
    for (int i = 0; i < 4; i++) begin
      push(fl[i], fr[i]);
      checks++; if (fifo_level !== 3'(i + 1)) begin errors++; $display("FAIL full_fill_level %0d: got %0d exp %0d", i, fifo_level, i + 1); end
    end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready: got %b exp 0", s_ready); end
    s_valid = 1'b1; s_left = 24'h333333; s_right = 24'h444444;
    step(); step();
    s_valid = 1'b0;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_hold_level: got %0d exp 4", fifo_level); end
    checks++; if (i2s_sd !== 1'b0) begin errors++; $display("FAIL dis_sd: got %b exp 0", i2s_sd); end
    enable = 1'b1;
    k = -1;
    for (int c = 0; c < 64; c++) begin
      goto(bit_step(0, c));
      checks++; if (i2s_sd !== 1'b0) begin errors++; $display("FAIL en_first_silent c=%0d: got %b exp 0", c, i2s_sd); end
    end
    goto(254);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_prepop_ready: got %b exp 0", s_ready); end
    goto(255);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL full_postpop_ready: got %b exp 1", s_ready); end
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL full_postpop_level: got %0d exp 3", fifo_level); end
    for (int c = 0; c < 64; c++) begin
      goto(bit_step(1, c));
      checks++;
      if (i2s_sd !== exp_sd(24, 32'(fl[0]), 32'(fr[0]), c)) begin
        errors++; $display("FAIL full_play0 c=%0d: got %b exp %b", c, i2s_sd, exp_sd(24, 32'(fl[0]), 32'(fr[0]), c));
      end
    end
    for (int c = 0; c <= 40; c++) begin
      goto(bit_step(2, c));
      checks++;
      if (i2s_sd !== exp_sd(24, 32'(fl[1]), 32'(fr[1]), c)) begin
        errors++; $display("FAIL full_play1 c=%0d: got %b exp %b", c, i2s_sd, exp_sd(24, 32'(fl[1]), 32'(fr[1]), c));
      end
    end
  endtask

  task automatic test_pll_drop();
    // Currently at cnt=40 of a frame with two frames still buffered.
    checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL pll_pre_level: got %0d exp 2", fifo_level); end
    pll_locked = 1'b0;
    step();
    checks++; if (i2s_lrclk !== 1'b0) begin errors++; $display("FAIL pll_lrclk: got %b exp 0", i2s_lrclk); end
    checks++; if (i2s_bclk !== 1'b0) begin errors++; $display("FAIL pll_bclk: got %b exp 0", i2s_bclk); end
    checks++; if (i2s_sd !== 1'b0) begin errors++; $display("FAIL pll_sd: got %b exp 0", i2s_sd); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL pll_level: got %0d exp 0", fifo_level); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL pll_s_ready: got %b exp 0", s_ready); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL pll_underrun: got %b exp 0", underrun); end
    checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL pll_ucnt: got %0d exp 0", underrun_cnt); end
    step();
    pll_locked = 1'b1;
    k = -1;
    goto(4);
    push(24'h5A0FF0, 24'hA5F00F);
    for (int c = 2; c < 64; c++) begin
      goto(bit_step(0, c));
      checks++; if (i2s_sd !== 1'b0) begin errors++; $display("FAIL relock_silent c=%0d: got %b exp 0", c, i2s_sd); end
    end
    for (int c = 0; c < 64; c++) begin
      goto(bit_step(1, c));
      checks++;
      if (i2s_sd !== exp_sd(24, 32'h5A0FF0, 32'hA5F00F, c)) begin
        errors++; $display("FAIL relock_play c=%0d: got %b exp %b", c, i2s_sd, exp_sd(24, 32'h5A0FF0, 32'hA5F00F, c));
      end
    end
  endtask

  task automatic test_dw16();
    reset16 = 1'b0;
    enable16 = 1'b1;
    k = -1;
    step();
    checks++; if (s_ready16 !== 1'b1) begin errors++; $display("FAIL dw16_ready: got %b exp 1", s_ready16); end
    s_valid16 = 1'b1; s_left16 = 16'h8001; s_right16 = 16'h4003;
    step();
    s_valid16 = 1'b0;
    checks++; if (level16 !== 3'd1) begin errors++; $display("FAIL dw16_level: got %0d exp 1", level16); end
    for (int c = 1; c < 64; c++) begin
      goto(bit_step(0, c));
      checks++; if (sd16 !== 1'b0) begin errors++; $display("FAIL dw16_silent c=%0d: got %b exp 0", c, sd16); end
    end
    for (int c = 0; c < 64; c++) begin
      goto(bit_step(1, c));
      checks++;
      if (sd16 !== exp_sd(16, 32'h8001, 32'h4003, c)) begin
        errors++; $display("FAIL dw16_sd c=%0d: got %b exp %b", c, sd16, exp_sd(16, 32'h8001, 32'h4003, c));
      end
      checks++; if (lrclk16 !== exp_lr(c)) begin errors++; $display("FAIL dw16_lr c=%0d: got %b exp %b", c, lrclk16, exp_lr(c)); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    k = 0;
    reset = 1'b1; pll_locked = 1'b1; enable = 1'b0; s_valid = 1'b0;
    s_left = '0; s_right = '0; underrun_clr = 1'b0;
    reset16 = 1'b1; enable16 = 1'b0; s_valid16 = 1'b0; s_left16 = '0; s_right16 = '0;
    test_reset();
    test_basic_frame();
    test_underrun();
    test_no_bypass();
    test_fifo_full();
    test_pll_drop();
    test_dw16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

I2S master transmitter clocked by the 12.288 MHz audio `mclk` from the audio PLL. It buffers stereo PCM frames from the system side in a small synchronous FIFO. It derives BCLK (3.072 MHz) and LRCLK (48 kHz) by dividing `mclk` down, and serialises 64-BCLK I2S frames to the external codec.

## Interface
- `DW`, 24, sample width in bits, legal range 16..32.
- `FIFO_DEPTH`, 4, FIFO depth in stereo frames, power of 2, at least 2.

Ports:
- `mclk` input 1: sole clock, 12.288 MHz.
- `reset` input 1: reset, synchronous and active-high.
- `pll_locked` input 1: low is treated exactly like `reset` (synchronous clear).
- `enable` input 1: run the serial clocks and frame engine.
- `s_valid` input 1: frame offered.
- `s_ready` output 1: frame accepted when `s_valid & s_ready`.
- `s_left` input DW: left sample, two's complement.
- `s_right` input DW: right sample, two's complement.
- `i2s_bclk` output 1: bit clock, `mclk`/4.
- `i2s_lrclk` output 1: word select; 0 = left, 1 = right.
- `i2s_sd` output 1: serial data, MSB first.
- `fifo_level` output $clog2(FIFO_DEPTH)+1: frames held in the FIFO.
- `underrun` output 1: sticky underrun flag.
- `underrun_clr` input 1: clears `underrun`.
- `underrun_cnt` output 16: underrun event counter.

## Operation
- **Reset values.** `reset` or `!pll_locked` forces all outputs to 0 except `s_ready`. The FIFO is emptied. `div` and `cnt` are cleared to 0. The shift register is cleared.
- **`s_ready`** is `!full`. It is 0 during reset because `s_ready` is registered as `!full & !reset`.
- **Divider.** 2-bit `div` increments every `mclk` while `enable=1`. `i2s_bclk = div[1]`, registered, so BCLK is low for 2 `mclk` and high for 2 `mclk`.
- **Bit counter.** 6-bit `cnt` advances when `div==3` (BCLK falling edge) and wraps 63→0.
- **Frame update.** All of `i2s_sd`, `i2s_lrclk` and shift-register updates happen only on the `div==3` cycle, so outputs change on BCLK falling edges.
- **LRCLK.** Becomes 1 when entering `cnt=31`. Becomes 0 when entering `cnt=63`. This gives the standard I2S one-BCLK lead.
- **Data slots.**
  - `cnt` 0..DW-1: left bits, MSB first.
  - `cnt` DW..31: 0.
  - `cnt` 32..32+DW-1: right bits, MSB first.
  - remaining bits: 0.
- **Frame load** occurs on the `div==3 & cnt==63` cycle.
  - FIFO non-empty: pop one frame into the left/right shift registers.
  - FIFO empty: load zeros, set `underrun`, increment `underrun_cnt`.
- **No bypass.** A push in the same cycle as a load while the FIFO is empty is still an underrun. The pushed frame is stored and plays next frame.
- **Push and pop in the same cycle:** `fifo_level` is unchanged. A push while full cannot occur, since `s_ready` is 0.
- **`underrun_clr` in the same cycle as a new underrun:** set wins.
- **`enable=0`:**
  - `div` and `cnt` are held at 0; `i2s_bclk`, `i2s_lrclk` and `i2s_sd` are held at 0.
  - The shift register is cleared.
  - The FIFO still accepts frames.
- **`enable` 0→1:** starts at `cnt=0`. The first frame (the one in flight) is silent. FIFO data plays from the following frame.
- **`enable` deasserted mid-frame:** the partial frame is abandoned and no pop occurs.

## Timing
- BCLK period: 4 `mclk`. LRCLK period: 256 `mclk` (48 kHz).
- `i2s_sd` and `i2s_lrclk` change 1 `mclk` after the BCLK falling edge, at the same registered edge as `i2s_bclk` going 0. Both are stable for the whole high phase.
- Input-to-line latency: a frame pushed into an empty FIFO before the load cycle has its left MSB on `i2s_sd` from the next `cnt=0`. Worst case is 256+4 `mclk`.
- `fifo_level` updates the cycle after a push or pop.

## Configuration
- `AUDIO_I2S_TX_UNDERRUN_CNT_EN`
  - Defined: `underrun_cnt` is a 16-bit counter saturating at 0xFFFF. It is cleared by `reset` or `underrun_clr`. If a clear and an event coincide, the result is 1.
  - Undefined: no counter logic; `underrun_cnt` is tied to 0. The `underrun` flag is unaffected.

## Structure
- Package `audio_pkg`:
  - `BCLK_DIV=4`, `FRAME_BITS=64`, `SLOT_BITS=32`.
  - LRCLK edge constants 31 and 63.
  - Load count 63.
- Sub-module `audio_sync_fifo` (parameters `WIDTH=2*DW`, `DEPTH`).
  - Single clock, synchronous reset; outputs full, empty and level.
  - Pointer wrap uses an extra MSB.

## Test plan
- **Reset:** hold `reset` 3 cycles → all outputs 0, `fifo_level=0`. Release with `enable=1` → `i2s_bclk` toggles with period 4 and `i2s_lrclk` with period 256.
- **Basic frame:** push L=0xA5A5A5, R=0x5A5A5A (DW=24) → next frame shows bits 1010…0101 in `cnt` 0..23, zeros in 24..31, 0101…1010 in 32..55, zeros after. LRCLK transitions occur at `cnt` 31 and 63.
- **Underrun:** push nothing for 2 frames → `i2s_sd` all zero, `underrun=1`, `underrun_cnt=2`. `underrun_clr` coinciding with a third event → `underrun=1`, count 1.
- **FIFO full:** push 4 frames with `enable=0` → `s_ready=0`, `fifo_level=4`. Enable → frames play in order; `s_ready` returns 1 after the first pop.
- **`pll_locked` drop mid-frame** at `cnt=40` → outputs 0 next cycle, FIFO empty. Relock → the first frame after relock is silent.
- **DW=16:** push L=0x8001 → MSB at `cnt=0`, LSB at `cnt=15`, zeros at 16..31.
